// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: the canonical NOP and the fetch-queue entry
// layout. Every squash point in the pipeline uses this NOP encoding.
package pipeline_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned TAG_W   = 1;

    // Canonical NOP substituted for empty or stale slots.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE320F000;

    // One fetched instruction together with its PC and branch epoch tag.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [TAG_W-1:0]   epoch;
    } fq_entry_t;

endpackage : pipeline_pkg

// File: rtl/fq_head_mux.sv
// Head-of-queue presentation logic: converts a stale head into the
// canonical NOP and flags it as squashed; forces NOP/0 when empty.
// Ports:
//   head_valid_i  - queue holds at least one entry
//   head_instr_i  - instruction stored at the head
//   head_pc_i     - PC stored at the head
//   head_epoch_i  - epoch tag stored at the head
//   cur_epoch_i   - live architectural epoch
//   out_instr_o   - head instruction or NOP (combinational)
//   out_pc_o      - head PC, 0 when empty (combinational)
//   out_squash_o  - head present but stale (combinational)
module fq_head_mux #(
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          ADDR_W    = 32,
    parameter int unsigned          EPOCH_W   = 1,
    parameter logic [DATA_W-1:0]    NOP_INSTR = 32'hE320F000
) (
    input  logic                 head_valid_i,
    input  logic [DATA_W-1:0]    head_instr_i,
    input  logic [ADDR_W-1:0]    head_pc_i,
    input  logic [EPOCH_W-1:0]   head_epoch_i,
    input  logic [EPOCH_W-1:0]   cur_epoch_i,
    output logic [DATA_W-1:0]    out_instr_o,
    output logic [ADDR_W-1:0]    out_pc_o,
    output logic                 out_squash_o
);

    // Epoch is compared live so a stalled head turns stale in the same cycle.
    always_comb begin
        out_squash_o = head_valid_i && (head_epoch_i != cur_epoch_i);
        out_pc_o     = head_valid_i ? head_pc_i : '0;
        out_instr_o  = (head_valid_i && !out_squash_o) ? head_instr_i : NOP_INSTR;
    end

endmodule : fq_head_mux

// File: rtl/fetch_queue.sv
// DEPTH-entry instruction buffer between fetch and decode with valid/ready
// handshakes, epoch-based squash at the head, bulk flush and occupancy.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   in_valid/in_ready            - fetch-side handshake
//   in_instr/in_pc/in_epoch      - entry offered by fetch
//   cur_epoch                    - live epoch from execute
//   flush                        - drop every entry (and the offered one)
//   out_valid/out_ready          - decode-side handshake
//   out_instr/out_pc/out_squash  - head presentation
//   count                        - current occupancy
module fetch_queue #(
    parameter int unsigned          DATA_W    = pipeline_pkg::INSTR_W,
    parameter int unsigned          ADDR_W    = pipeline_pkg::PC_W,
    parameter int unsigned          DEPTH     = 4,
    parameter int unsigned          EPOCH_W   = pipeline_pkg::TAG_W,
    parameter logic [DATA_W-1:0]    NOP_INSTR = DATA_W'(pipeline_pkg::NOP_INSTR)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_instr,
    input  logic [ADDR_W-1:0]             in_pc,
    input  logic [EPOCH_W-1:0]            in_epoch,
    input  logic [EPOCH_W-1:0]            cur_epoch,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_instr,
    output logic [ADDR_W-1:0]             out_pc,
    output logic                          out_squash,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0]  instr;
        logic [ADDR_W-1:0]  pc;
        logic [EPOCH_W-1:0] epoch;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push, pop;
    entry_t             head;

    // in_ready depends only on registered occupancy: no bypass of a full queue.
    assign in_ready  = (cnt_q < CNT_W'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign count     = cnt_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];

    // Pointer/occupancy next state; flush discards everything including the offer.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; a write during flush lands in a dead slot.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{instr: in_instr, pc: in_pc, epoch: in_epoch};
        end
    end

    fq_head_mux #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .EPOCH_W   (EPOCH_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_head_mux (
        .head_valid_i (out_valid),
        .head_instr_i (head.instr),
        .head_pc_i    (head.pc),
        .head_epoch_i (head.epoch),
        .cur_epoch_i  (cur_epoch),
        .out_instr_o  (out_instr),
        .out_pc_o     (out_pc),
        .out_squash_o (out_squash)
    );

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue (DEPTH=4, 32-bit instr/PC, 1-bit epoch).
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'hE320F000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        epoch;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        in_epoch = 1'b0;
    logic        cur_epoch = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_squash;
    logic [2:0]  count;

    ent_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_epoch   (in_epoch),
        .cur_epoch  (cur_epoch),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_squash (out_squash),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Reference model of the head, taken from the scoreboard queue.
    function automatic logic m_valid();
        return sb.size() > 0;
    endfunction
    function automatic logic m_squash();
        return (sb.size() > 0) && (sb[0].epoch != cur_epoch);
    endfunction
    function automatic logic [31:0] m_instr();
        if (sb.size() == 0 || sb[0].epoch != cur_epoch) return NOP;
        return sb[0].instr;
    endfunction
    function automatic logic [31:0] m_pc();
        return (sb.size() > 0) ? sb[0].pc : 32'h0;
    endfunction
    function automatic logic [2:0] m_count();
        return 3'(sb.size());
    endfunction

    // Advance one clock; model decides push/pop from its own occupancy.
    task automatic tick();
        logic p, q;
        ent_t e;
        p = in_valid && (sb.size() < DEPTH);
        q = (sb.size() > 0) && out_ready;
        e = '{instr: in_instr, pc: in_pc, epoch: in_epoch};
        @(posedge clk);
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (q) void'(sb.pop_front());
            if (p) sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic offer(input logic v, input logic [31:0] i, input logic [31:0] pc,
                         input logic ep);
        in_valid = v;
        in_instr = i;
        in_pc    = pc;
        in_epoch = ep;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vectors++;
        if (out_instr !== NOP) begin miscompares++; $display("FAIL reset_out_instr got=%h exp=%h", out_instr, NOP); end
        vectors++;
        if (out_pc !== 32'h0) begin miscompares++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
        vectors++;
        if (out_squash !== 1'b0) begin miscompares++; $display("FAIL reset_out_squash got=%b exp=0", out_squash); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        vectors++;
        if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 32'h1000_0000 + 32'(i), 32'h100 + 32'(4 * i), 1'b0);
            tick();
        end
        offer(1'b1, 32'hDEAD_BEEF, 32'hBAD0, 1'b0);
        #1;
        vectors++;
        if (count !== 3'd4) begin miscompares++; $display("FAIL full_count got=%0d exp=4", count); end
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        tick();
        #1;
        vectors++;
        if (count !== 3'd4) begin miscompares++; $display("FAIL full_5th_ignored got=%0d exp=4", count); end
        offer(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (out_instr !== m_instr() || out_pc !== m_pc() || out_valid !== m_valid()) begin
                miscompares++;
                $display("FAIL drain_%0d got=%h/%h/%b exp=%h/%h/%b", i, out_instr, out_pc,
                         out_valid, m_instr(), m_pc(), m_valid());
            end
            tick();
        end
        #1;
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL drained_empty got=%0d/%b exp=0/0", count, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            offer(1'b1, 32'h2000_0000 + 32'(i), 32'h400 + 32'(4 * i), 1'b0);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 2; i < 22; i++) begin
            offer(1'b1, 32'h2000_0000 + 32'(i), 32'h400 + 32'(4 * i), 1'b0);
            #1;
            vectors++;
            if (out_instr !== m_instr() || out_pc !== m_pc() || count !== 3'd2) begin
                miscompares++;
                $display("FAIL stream_%0d got=%h/%h/%0d exp=%h/%h/2", i, out_instr, out_pc,
                         count, m_instr(), m_pc());
            end
            tick();
        end
        offer(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (out_instr !== m_instr() || out_pc !== m_pc()) begin
                miscompares++;
                $display("FAIL stream_tail_%0d got=%h/%h exp=%h/%h", i, out_instr, out_pc,
                         m_instr(), m_pc());
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_epoch();
        cur_epoch = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 32'h3000_0000 + 32'(i), 32'h800 + 32'(4 * i), (i >= 2));
            tick();
        end
        offer(1'b0, '0, '0, 1'b0);
        #1;
        vectors++;
        if (out_squash !== 1'b0 || out_instr !== 32'h3000_0000) begin
            miscompares++; $display("FAIL epoch_fresh got=%b/%h exp=0/30000000", out_squash, out_instr);
        end
        cur_epoch = 1'b1;
        #1;
        vectors++;
        if (out_squash !== 1'b1 || out_instr !== NOP || out_pc !== 32'h800) begin
            miscompares++;
            $display("FAIL epoch_stale got=%b/%h/%h exp=1/%h/800", out_squash, out_instr, out_pc, NOP);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (out_squash !== m_squash() || out_instr !== m_instr() || out_pc !== m_pc()) begin
                miscompares++;
                $display("FAIL epoch_drain_%0d got=%b/%h/%h exp=%b/%h/%h", i, out_squash,
                         out_instr, out_pc, m_squash(), m_instr(), m_pc());
            end
            tick();
        end
        out_ready = 1'b0;
        cur_epoch = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 32'h4000_0000 + 32'(i), 32'hC00 + 32'(4 * i), 1'b0);
            tick();
        end
        offer(1'b1, 32'h4444_4444, 32'hCCC, 1'b0);
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        vectors++;
        if (count !== 3'd3 || out_valid !== 1'b1 || out_pc !== 32'hC00) begin
            miscompares++;
            $display("FAIL flush_prehead got=%0d/%b/%h exp=3/1/c00", count, out_valid, out_pc);
        end
        tick();
        flush = 1'b0;
        offer(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (count !== 3'd0 || out_valid !== 1'b0 || out_instr !== NOP) begin
                miscompares++;
                $display("FAIL flush_empty_%0d got=%0d/%b/%h exp=0/0/%h", i, count, out_valid,
                         out_instr, NOP);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            offer(1'b1, 32'h5000_0000 + 32'(i), 32'h1000 + 32'(4 * i), 1'b0);
            tick();
        end
        offer(1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset got=%0d/%b/%b/%h exp=0/0/1/0", count, out_valid, in_ready, out_pc);
        end
        offer(1'b1, 32'h6000_0001, 32'h2000, 1'b0);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL no_fallthrough got=%b exp=0", out_valid); end
        tick();
        offer(1'b0, '0, '0, 1'b0);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_instr !== 32'h6000_0001 || out_pc !== 32'h2000) begin
            miscompares++;
            $display("FAIL post_reset_push got=%b/%h/%h exp=1/60000001/2000", out_valid, out_instr, out_pc);
        end
        vectors++;
        if (out_instr !== m_instr() || count !== m_count()) begin
            miscompares++;
            $display("FAIL post_reset_model got=%h/%0d exp=%h/%0d", out_instr, count, m_instr(), m_count());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_epoch();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fetch_queue
